// File: rtl/sync_down_counter_if.sv
// sync_down_counter_if
//
// Control and status bundle for sync_down_counter. clk and reset_n are plain
// ports on the counter and are not part of this bundle.
//
//   load      master->slave  load load_val on the next edge (beats en)
//   load_val  master->slave  start value, n bits
//   en        master->slave  count enable
//   Q         slave->master  current count, n bits
//   busy      slave->master  counter is in COUNT
//   done      slave->master  counter is in DONE
//   tc        slave->master  one-cycle terminal-count pulse
interface sync_down_counter_if #(
    parameter int n = 4
) ();
    logic         load;
    logic [n-1:0] load_val;
    logic         en;
    logic [n-1:0] Q;
    logic         busy;
    logic         done;
    logic         tc;

    modport master (
        output load, load_val, en,
        input  Q, busy, done, tc
    );

    modport slave (
        input  load, load_val, en,
        output Q, busy, done, tc
    );
endinterface

// File: rtl/sync_down_counter.sv
// sync_down_counter
//
// Loadable down-counter / countdown timer. The count register is a chain of
// T_FF cells driven by borrow-chain toggle logic. A nonzero load starts a
// countdown; each enabled edge decrements; the edge that takes Q from 1 to 0
// is the terminal event, flagged by a registered one-cycle tc pulse.
//
// Optional feature macro: SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
//   defined   - terminal event reloads Q from the last accepted nonzero
//               load value and stays in COUNT; done is tied low.
//   undefined - terminal event enters DONE with Q held at 0 until a load.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears everything
//   bus      sync_down_counter_if.slave (load, load_val, en, Q, busy,
//            done, tc)
//
// Also contains T_FF, the toggle flip-flop cell of the count register:
//   clk, reset_n (async active-low, resets Q to 0), T (toggle), Q.
module sync_down_counter #(
    parameter int n = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    sync_down_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // What the toggle inputs do on the coming edge.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_DEC  = 2'd1,
        OP_LOAD = 2'd2
    } op_t;

    localparam logic [n-1:0] ONE = n'(1);

    state_t       state;
    state_t       state_nxt;
    op_t          op;
    logic [n-1:0] q;
    logic [n-1:0] load_target;
    logic [n-1:0] t_dec;
    logic [n-1:0] t_vec;
    logic         tc_r;
    logic         tc_nxt;
    logic         load_nz;

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [n-1:0] reload_r;
`endif

    assign load_nz = |bus.load_val;

    // Count register: one toggle cell per bit.
    for (genvar i = 0; i < n; i++) begin : g_bit
        T_FF u_tff (
            .clk     (clk),
            .reset_n (reset_n),
            .T       (t_vec[i]),
            .Q       (q[i])
        );
    end

    // Borrow chain: bit i flips when every lower bit is 0.
    always_comb begin
        t_dec    = '0;
        t_dec[0] = 1'b1;
        for (int i = 1; i < n; i++) begin
            t_dec[i] = t_dec[i-1] & ~q[i-1];
        end
    end

    // A load toggles exactly the bits that differ from the target.
    always_comb begin
        unique case (op)
            OP_DEC:  t_vec = t_dec;
            OP_LOAD: t_vec = q ^ load_target;
            default: t_vec = '0;
        endcase
    end

    // Next-state / operation select. Load always wins over en, so a load on
    // the terminal edge suppresses tc.
    always_comb begin
        state_nxt   = state;
        op          = OP_HOLD;
        load_target = bus.load_val;
        tc_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.load && load_nz) begin
                    state_nxt = COUNT;
                    op        = OP_LOAD;
                end
            end

            COUNT: begin
                if (bus.load) begin
                    // load_val of 0 clears Q and drops back to IDLE.
                    op        = OP_LOAD;
                    state_nxt = load_nz ? COUNT : IDLE;
                end else if (bus.en) begin
                    if (q == ONE) begin
                        tc_nxt = 1'b1;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
                        op          = OP_LOAD;
                        load_target = reload_r;
`else
                        op        = OP_DEC;
                        state_nxt = DONE;
`endif
                    end else begin
                        op = OP_DEC;
                    end
                end
            end

            DONE: begin
                // Q is already 0, so a zero load changes only the state.
                if (bus.load) begin
                    op        = OP_LOAD;
                    state_nxt = load_nz ? COUNT : IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            tc_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            tc_r  <= tc_nxt;
        end
    end

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    // Remembers the last accepted nonzero start value for auto-reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_r <= '0;
        end else if (bus.load && load_nz) begin
            reload_r <= bus.load_val;
        end
    end

    assign bus.done = 1'b0;
`else
    assign bus.done = (state == DONE);
`endif

    assign bus.Q    = q;
    assign bus.busy = (state == COUNT);
    assign bus.tc   = tc_r;

endmodule

module T_FF (
    input  logic clk,
    input  logic reset_n,
    input  logic T,
    output logic Q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter
//
// Scoreboard bench for sync_down_counter. The driver applies one input vector
// per cycle on the falling edge, advances an integer reference model of the
// countdown timer and queues the outputs expected after the next rising edge.
// A free-running monitor pops one entry per rising edge and compares.
module tb_sync_down_counter;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] q;
        logic         busy;
        logic         done;
        logic         tc;
    } exp_t;

    logic clk;
    logic reset_n;

    sync_down_counter_if #(.n(N)) bus ();

    sync_down_counter #(.n(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    // Reference model: mode 0 = idle, 1 = counting, 2 = expired.
    int m_cnt;
    int m_mode;
    int m_reload;
    int m_tc;

    function automatic exp_t model_out();
        exp_t e;
        e.q    = N'(m_cnt);
        e.busy = (m_mode == 1);
        e.done = (m_mode == 2);
        e.tc   = (m_tc != 0);
        return e;
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_mode   = 0;
        m_reload = 0;
        m_tc     = 0;
    endtask

    task automatic model_step(input bit ld, input int lv, input bit e);
        m_tc = 0;
        if (ld) begin
            if (lv != 0) begin
                m_mode   = 1;
                m_cnt    = lv;
                m_reload = lv;
            end else begin
                m_mode = 0;
                m_cnt  = 0;
            end
        end else if (m_mode == 1 && e) begin
            if (m_cnt == 1) begin
                m_tc = 1;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
                m_cnt = m_reload;
`else
                m_cnt  = 0;
                m_mode = 2;
`endif
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic compare(input string tag, input exp_t act, input exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got Q=%0d busy=%b done=%b tc=%b, want Q=%0d busy=%b done=%b tc=%b",
                     tag, act.q, act.busy, act.done, act.tc,
                     exp.q, exp.busy, exp.done, exp.tc);
        end
    endtask

    function automatic exp_t dut_out();
        exp_t a;
        a.q    = bus.Q;
        a.busy = bus.busy;
        a.done = bus.done;
        a.tc   = bus.tc;
        return a;
    endfunction

    // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                compare("cycle", dut_out(), e);
            end
        end
    end

    task automatic step(input bit ld, input int lv, input bit e);
        @(negedge clk);
        bus.load     = ld;
        bus.load_val = N'(lv);
        bus.en       = e;
        model_step(ld, lv, e);
        sb.push_back(model_out());
    endtask

    task automatic run_en(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 1'b1);
    endtask

    // Asserts reset between edges, after the monitor has consumed the last
    // pending expectation, and checks the outputs clear without a clock.
    task automatic mid_cycle_reset();
        exp_t zero;
        zero = '0;
        @(posedge clk);
        #2;
        bus.load = 1'b0;
        bus.en   = 1'b0;
        reset_n  = 1'b0;
        #1;
        compare("async_reset", dut_out(), zero);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        exp_t zero;
        zero         = '0;
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.en       = 1'b0;
        model_reset();

        #2;
        compare("reset_state", dut_out(), zero);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // IDLE ignores en.
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);

        // Basic countdown then 10 enabled cycles parked at zero.
        step(1'b1, 5, 1'b0);
        run_en(5);
        run_en(10);

        // Enable gating.
        step(1'b1, 4, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        run_en(2);

        // Full range: 15 enabled edges to expiry, no wrap afterwards.
        step(1'b1, 15, 1'b0);
        run_en(15);
        run_en(3);

        // Zero loads: from DONE back to IDLE, then stay IDLE.
        step(1'b1, 0, 1'b1);
        step(1'b1, 0, 1'b1);
        run_en(2);

        // Load beats the terminal event.
        step(1'b1, 2, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 9, 1'b1);
        run_en(3);

        // Restart mid-count at Q=4.
        step(1'b1, 6, 1'b0);
        run_en(2);
        step(1'b1, 7, 1'b0);
        run_en(8);

        // Zero load while counting drops to IDLE.
        step(1'b1, 3, 1'b0);
        step(1'b1, 0, 1'b1);
        run_en(2);

        // Reset mid-count at Q=3; first edge after release stays IDLE.
        step(1'b1, 5, 1'b0);
        run_en(2);
        mid_cycle_reset();
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bit ld;
            int lv;
            bit e;
            ld = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0:       lv = 0;
                1:       lv = (1 << N) - 1;
                2:       lv = 1;
                default: lv = int'($urandom_range(0, (1 << N) - 1));
            endcase
            e = ($urandom_range(0, 3) != 0);
            step(ld, lv, e);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Loadable synchronous down-counter and countdown timer. The count register is a chain of `T_FF` instances with borrow-chain toggle logic, the mirror of the team's synchronous up-counter. It counts a loaded value down to zero under an enable and flags expiry with a one-cycle terminal-count pulse. It is used wherever a block needs to wait a programmed number of enabled cycles.

## Interface
- `n`, default 4: counter width in bits; legal range 2–16.
- `clk`  input  1: rising-edge clock, the only clock.
- `reset_n`  input  1: asynchronous, active-low reset.
- `load`  input  1: load `load_val` on the next edge; has priority over `en`.
- `load_val`  input  n: start value.
- `en`  input  1: count enable; one decrement per edge while in COUNT.
- `Q`  output  n: current count, taken directly from the `T_FF` outputs.
- `busy`  output  1: high while the state is COUNT.
- `done`  output  1: high while the state is DONE.
- `tc`  output  1: registered terminal-count pulse, one cycle wide.

## Operation
- Count register:
  - Built from n `T_FF` instances (ports `clk`, `reset_n`, `T`, `Q`; reset to 0).
  - Decrement toggles: `T[0]=1`; `T[i]=T[i-1] & ~Q[i-1]`.
  - Load: `T = Q ^ next_val`.
  - Hold: `T = 0`.
- States are IDLE, COUNT and DONE, held in a 2-bit register. Reset enters IDLE.
- IDLE:
  - `Q=0`, `busy=0`, `done=0`.
  - `load` with a nonzero `load_val` goes to COUNT with `Q=load_val`.
  - `load` with `load_val=0` stays in IDLE. No `tc` is generated.
  - `en` is ignored.
- COUNT:
  - `en=1` and `Q>1`: Q decrements by 1.
  - `en=1` and `Q==1`: terminal event. Q becomes 0, `tc` is asserted, and the state goes to DONE. With `SYNC_DOWN_COUNTER_AUTO_RELOAD_EN`, see Configuration.
  - `en=0`: Q holds.
- DONE:
  - `Q=0`, `done=1`.
  - The counter never wraps to all-ones; `en` is ignored.
  - `load` with a nonzero value goes to COUNT; `load` with 0 goes to IDLE.
- Load in COUNT restarts the count from `load_val` (or goes to IDLE if `load_val=0`).
- Load and a terminal event on the same edge: load wins and no `tc` is generated.
- Reload register:
  - n bits, reset to 0.
  - Captures `load_val` on every accepted nonzero load.
  - Exists only when the macro is defined.
- Arithmetic is unsigned modulo 2^n. A value of `load_val=2^n-1` counts fully down with no overflow path.

## Timing
- Load sampled at edge k: Q equals `load_val` and `busy=1` after edge k.
- With `en` held high from edge k+1, the terminal event occurs at edge k+`load_val`.
- `tc` is high for exactly the one cycle following the terminal edge. That is the first cycle with Q=0 (or the first reloaded cycle when the macro is defined).
- `busy`, `done` and `tc` are registered and change only on `clk` edges, except at reset.
- Reset values: `Q=0`, `busy=0`, `done=0`, `tc=0`, state IDLE, reload register 0.
- `reset_n` low at any time, including mid-count, clears everything immediately, asynchronously. Operation resumes on the first edge after deassertion.

## Configuration
- Macro: `SYNC_DOWN_COUNTER_AUTO_RELOAD_EN`.
- Defined:
  - The terminal event in COUNT loads Q from the reload register, pulses `tc`, and stays in COUNT.
  - DONE is unreachable from counting and is entered only by… nothing; it stays unreachable. `done` is constant 0 in this case.
  - Load behaviour is unchanged.
- Undefined:
  - The reload register is not built.
  - The terminal event goes to DONE and Q holds 0 until the next load.

## Test plan
- Reset: assert `reset_n=0` mid-count at Q=3 -> `Q=0`, `busy=0`, `done=0`, `tc=0` immediately. First edge after release keeps IDLE.
- Basic countdown (n=4, macro off): load 5, then `en=1` -> Q sequence 5,4,3,2,1,0. `tc=1` only in the first Q=0 cycle. Then `done=1`, `busy=0`, and Q stays 0 for 10 more enabled cycles.
- Enable gating: load 4, toggle `en` 1,0,0,1,1,0,1 -> Q sequence 4,3,3,3,2,1,1,0. `tc` asserted once.
- Full range and zero load:
  - Load 15 with `en` continuous -> `tc` after exactly 15 enabled edges, no wrap.
  - Load 0 -> remains IDLE with `Q=0` and no `tc`.
- Collisions:
  - At Q=1 with `en=1`, `load=1`, `load_val=9` -> Q=9, `busy=1`, no `tc`.
  - Load 7 at Q=4 -> restarts at 7.
- Auto-reload (macro on): load 3, `en` high -> Q sequence 3,2,1,3,2,1,3… `tc` high in each cycle Q returns to 3. `done` is never set.
